// File: rtl/i2c_slave_byte_ctrl_if.sv
// Host-side strobe interface of the I2C target byte controller.
// Also carries the controller FSM state as a debug observation point.
interface i2c_slave_byte_ctrl_if;
   // Handshake: rx_vld_o, tx_req_o, stop_o and nack_o are single-cycle pulses
   // with no back-pressure. rx_dat_o is valid in the cycle rx_vld_o is high.
   // After tx_req_o the host holds tx_dat_i stable until the byte is latched.
   // ack_i is sampled when a write byte completes.
   logic [6:0] addr_i;
   logic       ack_i;
   logic [7:0] tx_dat_i;
   logic [7:0] rx_dat_o;
   logic       rx_vld_o;
   logic       tx_req_o;
   logic       sel_o;
   logic       rw_o;
   logic       busy_o;
   logic       stop_o;
   logic       nack_o;
   logic [2:0] dbg_state;

   modport slave (
      input  addr_i, ack_i, tx_dat_i,
      output rx_dat_o, rx_vld_o, tx_req_o, sel_o, rw_o, busy_o, stop_o, nack_o,
      output dbg_state
   );

   modport master (
      output addr_i, ack_i, tx_dat_i,
      input  rx_dat_o, rx_vld_o, tx_req_o, sel_o, rw_o, busy_o, stop_o, nack_o,
      input  dbg_state
   );
endinterface

// File: rtl/i2c_slave_byte_ctrl.sv
// Byte-level I2C target: oversampled SCL/SDA, START/STOP detect, 7-bit address match.
// Define I2C_SLV_GCALL_EN to also ACK the general call address (8'h00, write).
module i2c_slave_byte_ctrl #(
   parameter int unsigned FILT_LEN = 3
) (
   input  logic                        clk_i,
   input  logic                        rst_i,
   input  logic                        en_i,
   input  logic                        scl_i,
   input  logic                        sda_i,
   output logic                        sda_o,
   output logic                        sda_dir_o,
   i2c_slave_byte_ctrl_if.slave        host
);

   typedef enum logic [2:0] {
      S_IDLE, S_ADDR, S_ADDR_ACK, S_WR_DAT, S_WR_ACK, S_RD_DAT, S_RD_ACK, S_WAIT
   } state_t;

   // Bit 0 carries SCL, bit 1 carries SDA through the input path.
   logic [1:0] sync1, sync2, filt, filt_q;
   logic [3:0] fcnt [2];

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         sync1   <= 2'b11;
         sync2   <= 2'b11;
         filt    <= 2'b11;
         filt_q  <= 2'b11;
         fcnt[0] <= 4'd0;
         fcnt[1] <= 4'd0;
      end else begin
         sync1  <= {sda_i, scl_i};
         sync2  <= sync1;
         filt_q <= filt;
         for (int i = 0; i < 2; i++) begin
            if (sync2[i] == filt[i]) begin
               fcnt[i] <= 4'd0;
            end else if (fcnt[i] == 4'(FILT_LEN - 1)) begin
               filt[i] <= sync2[i];
               fcnt[i] <= 4'd0;
            end else begin
               fcnt[i] <= fcnt[i] + 4'd1;
            end
         end
      end
   end

   logic sda_f, scl_rise, scl_fall, start_ev, stop_ev;
   assign sda_f    = filt[1];
   assign scl_rise =  filt[0] & ~filt_q[0];
   assign scl_fall = ~filt[0] &  filt_q[0];
   // SDA may only change with SCL held high across both samples to count as START/STOP.
   assign start_ev = filt[0] & filt_q[0] &  filt_q[1] & ~filt[1];
   assign stop_ev  = filt[0] & filt_q[0] & ~filt_q[1] &  filt[1];

   state_t     state, state_n;
   logic [3:0] bitcnt, bitcnt_n;
   logic [7:0] sh, sh_n, txsh, txsh_n, rx_dat, rx_dat_n;
   logic       sel, sel_n, rw, rw_n, busy, busy_n, sda_dir, sda_dir_n;
   logic       rd_acked, rd_acked_n;
   logic       rx_vld, rx_vld_n, tx_req, tx_req_n, stop_p, stop_n, nack_p, nack_n;
   logic       addr_hit;

   always_comb begin
`ifdef I2C_SLV_GCALL_EN
      addr_hit = (sh[7:1] == 7'h00) ? ~sh[0] : (sh[7:1] == host.addr_i);
`else
      addr_hit = (sh[7:1] == host.addr_i);
`endif
   end

   always_comb begin
      state_n    = state;
      bitcnt_n   = bitcnt;
      sh_n       = sh;
      txsh_n     = txsh;
      rx_dat_n   = rx_dat;
      sel_n      = sel;
      rw_n       = rw;
      busy_n     = busy;
      sda_dir_n  = sda_dir;
      rd_acked_n = rd_acked;
      rx_vld_n   = 1'b0;
      tx_req_n   = 1'b0;
      stop_n     = 1'b0;
      nack_n     = 1'b0;
      if (!en_i) begin
         state_n   = S_IDLE;
         sda_dir_n = 1'b0;
         sel_n     = 1'b0;
         busy_n    = 1'b0;
         bitcnt_n  = 4'd0;
      end else if (stop_ev) begin
         state_n   = S_IDLE;
         sda_dir_n = 1'b0;
         busy_n    = 1'b0;
         stop_n    = sel;
         sel_n     = 1'b0;
      end else if (start_ev) begin
         state_n   = S_ADDR;
         sda_dir_n = 1'b0;
         busy_n    = 1'b1;
         sel_n     = 1'b0;
         bitcnt_n  = 4'd0;
      end else begin
         unique case (state)
            S_ADDR, S_WR_DAT: begin
               if (scl_rise && bitcnt != 4'd8) begin
                  sh_n     = {sh[6:0], sda_f};
                  bitcnt_n = bitcnt + 4'd1;
               end else if (scl_fall && bitcnt == 4'd8) begin
                  if (state == S_WR_DAT) begin
                     rx_dat_n  = sh;
                     rx_vld_n  = 1'b1;
                     sda_dir_n = host.ack_i;
                     state_n   = S_WR_ACK;
                  end else if (addr_hit) begin
                     sel_n     = 1'b1;
                     rw_n      = sh[0];
                     sda_dir_n = 1'b1;
                     tx_req_n  = sh[0];
                     state_n   = S_ADDR_ACK;
                  end else begin
                     sda_dir_n = 1'b0;
                     state_n   = S_WAIT;
                  end
               end
            end
            S_ADDR_ACK, S_WR_ACK: begin
               if (scl_fall) begin
                  bitcnt_n = 4'd0;
                  if (state == S_ADDR_ACK && rw) begin
                     txsh_n    = host.tx_dat_i;
                     sda_dir_n = ~host.tx_dat_i[7];
                     bitcnt_n  = 4'd1;
                     state_n   = S_RD_DAT;
                  end else begin
                     sda_dir_n = 1'b0;
                     state_n   = S_WR_DAT;
                  end
               end
            end
            S_RD_DAT: begin
               // bitcnt counts bits already placed on the bus.
               if (scl_fall) begin
                  if (bitcnt == 4'd8) begin
                     sda_dir_n = 1'b0;
                     state_n   = S_RD_ACK;
                  end else begin
                     txsh_n    = {txsh[6:0], 1'b0};
                     sda_dir_n = ~txsh[6];
                     bitcnt_n  = bitcnt + 4'd1;
                  end
               end
            end
            S_RD_ACK: begin
               if (scl_rise) begin
                  rd_acked_n = ~sda_f;
                  tx_req_n   = ~sda_f;
                  nack_n     = sda_f;
               end else if (scl_fall) begin
                  if (rd_acked) begin
                     txsh_n    = host.tx_dat_i;
                     sda_dir_n = ~host.tx_dat_i[7];
                     bitcnt_n  = 4'd1;
                     state_n   = S_RD_DAT;
                  end else begin
                     state_n   = S_WAIT;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state    <= S_IDLE;
         bitcnt   <= 4'd0;
         sh       <= 8'h00;
         txsh     <= 8'h00;
         rx_dat   <= 8'h00;
         sel      <= 1'b0;
         rw       <= 1'b0;
         busy     <= 1'b0;
         sda_dir  <= 1'b0;
         rd_acked <= 1'b0;
         rx_vld   <= 1'b0;
         tx_req   <= 1'b0;
         stop_p   <= 1'b0;
         nack_p   <= 1'b0;
      end else begin
         state    <= state_n;
         bitcnt   <= bitcnt_n;
         sh       <= sh_n;
         txsh     <= txsh_n;
         rx_dat   <= rx_dat_n;
         sel      <= sel_n;
         rw       <= rw_n;
         busy     <= busy_n;
         sda_dir  <= sda_dir_n;
         rd_acked <= rd_acked_n;
         rx_vld   <= rx_vld_n;
         tx_req   <= tx_req_n;
         stop_p   <= stop_n;
         nack_p   <= nack_n;
      end
   end

   assign sda_o          = 1'b0;
   assign sda_dir_o      = sda_dir;
   assign host.rx_dat_o  = rx_dat;
   assign host.rx_vld_o  = rx_vld;
   assign host.tx_req_o  = tx_req;
   assign host.sel_o     = sel;
   assign host.rw_o      = rw;
   assign host.busy_o    = busy;
   assign host.stop_o    = stop_p;
   assign host.nack_o    = nack_p;
   assign host.dbg_state = state;

endmodule

// File: tb/tb_i2c_slave_byte_ctrl.sv
// Bench for i2c_slave_byte_ctrl: a bit-banged I2C master drives the pads, a host
// process answers tx_req_o, and a monitor compares host pulses against expected events.
module tb_i2c_slave_byte_ctrl;
   localparam int Q    = 10;
   localparam int FILT = 3;
   localparam logic [3:0] EV_RXV = 4'd1, EV_TXREQ = 4'd2, EV_NACK = 4'd3, EV_STOP = 4'd4;
   localparam logic [2:0] ST_IDLE = 3'd0, ST_WAIT = 3'd7;
`ifdef I2C_SLV_GCALL_EN
   localparam bit GCALL = 1'b1;
`else
   localparam bit GCALL = 1'b0;
`endif

   logic clk = 1'b0, rst = 1'b1, en = 1'b0;
   logic scl_m = 1'b1, sda_m = 1'b1;
   logic sda_o, sda_dir_o, sda_bus;
   logic [6:0] own_addr;
   logic [11:0] exp_q[$];
   logic [7:0]  host_q[$];
   logic [7:0]  wr_q[$];
   logic [7:0]  rd_q[$];
   int chk_cnt = 0, pass_cnt = 0;

   i2c_slave_byte_ctrl_if hif ();

   // Open-drain bus: either side may pull low.
   assign sda_bus = sda_m & ~(sda_dir_o & ~sda_o);

   i2c_slave_byte_ctrl #(.FILT_LEN(FILT)) dut (
      .clk_i(clk), .rst_i(rst), .en_i(en), .scl_i(scl_m), .sda_i(sda_bus),
      .sda_o(sda_o), .sda_dir_o(sda_dir_o), .host(hif)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      chk_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic wait_clk(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Reference model: which address bytes the target acknowledges.
   function automatic logic model_match(input logic [7:0] ab);
      if (GCALL && ab[7:1] == 7'h00) return ~ab[0];
      return ab[7:1] == own_addr;
   endfunction

   // Monitor and host responder.
   task automatic mon_evt(input logic [3:0] k, input logic [7:0] d);
      logic [11:0] e;
      e = 12'hFFF;
      if (exp_q.size() != 0) e = exp_q.pop_front();
      check("event", {k, d}, e);
   endtask

   initial begin
      hif.tx_dat_i = 8'h00;
      forever begin
         @(negedge clk);
         if (hif.rx_vld_o) mon_evt(EV_RXV, hif.rx_dat_o);
         if (hif.tx_req_o) begin
            mon_evt(EV_TXREQ, 8'h00);
            if (host_q.size() != 0) hif.tx_dat_i = host_q.pop_front();
            else hif.tx_dat_i = 8'hFF;
         end
         if (hif.nack_o) mon_evt(EV_NACK, 8'h00);
         if (hif.stop_o) mon_evt(EV_STOP, 8'h00);
      end
   end

   // Master bus driver.
   task automatic bus_start();
      sda_m = 1'b1; wait_clk(Q);
      scl_m = 1'b1; wait_clk(Q);
      sda_m = 1'b0; wait_clk(Q);
      scl_m = 1'b0; wait_clk(Q);
   endtask

   task automatic bus_stop();
      wait_clk(Q);
      sda_m = 1'b0; wait_clk(Q);
      scl_m = 1'b1; wait_clk(Q);
      sda_m = 1'b1; wait_clk(2 * Q);
   endtask

   task automatic clk_bit(input logic b, output logic r);
      wait_clk(Q);
      sda_m = b; wait_clk(Q);
      scl_m = 1'b1; wait_clk(Q);
      r = sda_bus; wait_clk(Q);
      scl_m = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] d, input logic glitch, output logic ack);
      logic r;
      for (int i = 7; i >= 0; i--) begin
         if (glitch && i == 3) begin
            wait_clk(Q);
            scl_m = 1'b1; wait_clk(FILT - 1);
            scl_m = 1'b0;
         end
         clk_bit(d[i], r);
      end
      clk_bit(1'b1, r);
      ack = ~r;
   endtask

   task automatic recv_byte(input logic m_ack, output logic [7:0] d);
      logic r;
      logic [7:0] t;
      t = 8'h00;
      for (int i = 7; i >= 0; i--) begin
         clk_bit(1'b1, r);
         t[i] = r;
      end
      clk_bit(~m_ack, r);
      d = t;
   endtask

   // Write transaction with the bytes in wr_q.
   task automatic do_write(input logic [7:0] ab, input logic rand_ack, input logic stop,
                           input logic glitch);
      logic m, a, ah;
      m = model_match(ab);
      bus_start();
      send_byte(ab, 1'b0, a);
      check("addr_ack", a, m);
      check("sel_after_addr", hif.sel_o, m);
      if (m) check("rw_after_addr", hif.rw_o, 1'b0);
      for (int k = 0; k < wr_q.size(); k++) begin
         ah = rand_ack ? 1'($urandom_range(0, 1)) : 1'b1;
         hif.ack_i = ah;
         if (m) exp_q.push_back({EV_RXV, wr_q[k]});
         send_byte(wr_q[k], glitch && k == 0, a);
         check("data_ack", a, m & ah);
      end
      if (stop) begin
         if (m) exp_q.push_back({EV_STOP, 8'h00});
         bus_stop();
         check("busy_after_stop", hif.busy_o, 1'b0);
         check("sel_after_stop", hif.sel_o, 1'b0);
      end
   endtask

   // Read transaction of rd_q bytes from own address; last byte NACKed.
   task automatic do_read();
      logic a;
      logic [7:0] d;
      foreach (rd_q[i]) host_q.push_back(rd_q[i]);
      bus_start();
      check("busy_after_start", hif.busy_o, 1'b1);
      exp_q.push_back({EV_TXREQ, 8'h00});
      send_byte({own_addr, 1'b1}, 1'b0, a);
      check("rd_addr_ack", a, 1'b1);
      check("rw_read", hif.rw_o, 1'b1);
      for (int k = 0; k < rd_q.size(); k++) begin
         if (k == rd_q.size() - 1) exp_q.push_back({EV_NACK, 8'h00});
         else exp_q.push_back({EV_TXREQ, 8'h00});
         recv_byte(k != rd_q.size() - 1, d);
         check("rd_data", d, rd_q[k]);
      end
      wait_clk(Q);
      check("state_wait_after_nack", hif.dbg_state, ST_WAIT);
      check("sda_released_after_nack", sda_dir_o, 1'b0);
      exp_q.push_back({EV_STOP, 8'h00});
      bus_stop();
      check("busy_after_rd_stop", hif.busy_o, 1'b0);
   endtask

   // Abort a read byte mid-flight by reset or disable.
   task automatic do_abort(input logic use_rst);
      logic a, r;
      host_q.push_back(8'h00);
      exp_q.push_back({EV_TXREQ, 8'h00});
      bus_start();
      send_byte({own_addr, 1'b1}, 1'b0, a);
      check("abort_addr_ack", a, 1'b1);
      for (int i = 0; i < 3; i++) clk_bit(1'b1, r);
      wait_clk(Q);
      check("abort_driving_before", sda_dir_o, 1'b1);
      if (use_rst) rst = 1'b1;
      else en = 1'b0;
      wait_clk(1);
      check("abort_sda_released", sda_dir_o, 1'b0);
      check("abort_sel", hif.sel_o, 1'b0);
      check("abort_busy", hif.busy_o, 1'b0);
      if (use_rst) check("abort_rx_dat_reset", hif.rx_dat_o, 8'h00);
      rst = 1'b0;
      wait_clk(Q);
      bus_stop();
      en = 1'b1;
      wait_clk(Q);
   endtask

   initial begin
      own_addr    = 7'h50;
      hif.addr_i  = own_addr;
      hif.ack_i   = 1'b1;
      rst = 1'b1;
      en  = 1'b1;
      wait_clk(4);
      rst = 1'b0;
      wait_clk(2);
      check("rst_sda_dir", sda_dir_o, 1'b0);
      check("rst_sda_o", sda_o, 1'b0);
      check("rst_sel", hif.sel_o, 1'b0);
      check("rst_rw", hif.rw_o, 1'b0);
      check("rst_busy", hif.busy_o, 1'b0);
      check("rst_rx_dat", hif.rx_dat_o, 8'h00);
      check("rst_state", hif.dbg_state, ST_IDLE);

      // Directed write, mismatch, read.
      wr_q = {8'h3C};
      do_write(8'hA0, 1'b0, 1'b1, 1'b0);
      check("rx_dat_3c", hif.rx_dat_o, 8'h3C);
      wr_q = {8'h55};
      do_write(8'hA2, 1'b0, 1'b1, 1'b0);
      rd_q = {8'hA5, 8'h5A};
      do_read();

      // Write then repeated start into a read.
      wr_q = {8'h01};
      do_write(8'hA0, 1'b0, 1'b0, 1'b0);
      check("rx_dat_01", hif.rx_dat_o, 8'h01);
      rd_q = {8'($urandom_range(0, 255))};
      do_read();

      // SCL glitch during a write byte.
      wr_q = {8'($urandom_range(0, 255)), 8'($urandom_range(0, 255))};
      do_write(8'hA0, 1'b0, 1'b1, 1'b1);
      check("rx_dat_after_glitch", hif.rx_dat_o, wr_q[1]);

      // General call address.
      wr_q = {8'h06};
      do_write(8'h00, 1'b0, 1'b1, 1'b0);

      do_abort(1'b0);
      do_abort(1'b1);

      // Randomized transactions.
      for (int t = 0; t < 8; t++) begin
         own_addr   = 7'($urandom_range(0, 127));
         hif.addr_i = own_addr;
         wait_clk(Q);
         if ($urandom_range(0, 2) == 0) begin
            rd_q = {};
            for (int k = 0; k < $urandom_range(1, 3); k++) rd_q.push_back(8'($urandom_range(0, 255)));
            do_read();
         end else begin
            wr_q = {};
            for (int k = 0; k < $urandom_range(1, 3); k++) wr_q.push_back(8'($urandom_range(0, 255)));
            if ($urandom_range(0, 1) == 0) do_write({own_addr, 1'b0}, 1'b1, 1'b1, 1'b0);
            else do_write({7'($urandom_range(0, 127)), 1'b0}, 1'b1, 1'b1, 1'b0);
         end
      end

      wait_clk(50);
      check("exp_queue_drained", exp_q.size(), 0);
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
